cpu_sequencer: RTL
==================

Name: cpu_sequencer

Overview:
- Parametrised fetch/execute controller for the 4-bit nibble CPU.
- Generates the phase internally instead of taking it as an input.
- Stretches memory-access instructions by a configurable number of RAM wait states, and supports halt/resume.
- Sits between the instruction/operand register and the datapath (PC, accumulator, ALU, RAM, I/O buffers) and drives every datapath control strobe.

Parameters:
- RAM_WAIT, 0, extra cycles RAM needs before data is valid (0..(2**WAIT_W)-1).
- WAIT_W, 4, width of the wait-state counter.
- FUN_W, 3, width of the ALU function code.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- instr  in  4  opcode from the instruction register, stable from the FETCH cycle onward.
- z_flag  in  1  registered zero flag.
- c_flag  in  1  registered carry flag.
- halt  in  1  request to stop at the next instruction boundary.
- incPC, loadPC, loadA, loadFlags  out  1 each  datapath strobes.
- fun  out  FUN_W  ALU function code.
- csRAM, weRAM, oeALU, oeIN, oeOprnd, loadOut  out  1 each  bus/memory controls.
- phase  out  2  current state encoding (RST=0, FETCH=1, ACCESS=2, EXEC=3); HALT is reported as 0.
- halted  out  1  high while in HALT.

Behaviour:
- States: RST, FETCH, ACCESS, EXEC, HALT. Outputs are combinational from state, the latched opcode and the flags (Moore, plus flag decode in EXEC).
- Reset (async, reset_n=0): state goes to RST; all outputs 0; wait counter 0. This applies mid-instruction, including an ACCESS in progress, with no partial write completion.
- RST: all outputs 0; next state FETCH.
- FETCH: outputs incPC=1, oeALU=1, all else 0.
  - If halt=1, next state is HALT.
  - Else the opcode is latched into an internal register. Next state is ACCESS if the opcode is a memory op and RAM_WAIT>0; otherwise EXEC.
- Memory ops: CMPM 0011, LD 0110, ST 0111, ADDM 1011, NANDM 1111.
- ACCESS:
  - Outputs csRAM=1; weRAM=1 only for ST; fun per opcode; oeALU per the opcode's EXEC word; incPC, loadPC, loadA, loadFlags, loadOut all 0.
  - The counter loads RAM_WAIT-1 on entry and decrements each cycle. At 0 the next state is EXEC.
  - Total cycles spent in ACCESS = RAM_WAIT.
- EXEC: outputs the opcode's control word (CW table in the package); next state FETCH.
  - Conditional jumps resolve with the flags sampled during EXEC:
    - JC 0000: c=1 gives loadPC, else incPC.
    - JNC 0001: inverse of JC.
    - JZ 1000: z=1 gives loadPC, else incPC.
    - JNZ 1001: inverse of JZ.
  - A jump word never asserts incPC and loadPC together.
- HALT: all strobes 0, oeALU=1, halted=1. Stays in HALT while halt=1; next state FETCH the cycle after halt=0. halt is ignored outside FETCH.
- The opcode register is updated only in FETCH. Changes on instr during ACCESS or EXEC have no effect.
- Instruction latency: 2 cycles for non-memory ops, 2+RAM_WAIT for memory ops.
- Exactly one of incPC/loadPC is asserted in every FETCH and EXEC cycle, except OUT, CMPI, LIT, IN, ADDI and NANDI, whose EXEC words have incPC=0.

Decomposition:
- Package cpu_pkg holds:
  - state encodings.
  - opcode constants OP_JC..OP_NANDM.
  - ALU function codes FUN_PASS=000, FUN_CMP=001, FUN_LOAD=010, FUN_ADD=011, FUN_NAND=100.
  - 13-bit control word bit positions.
  - CW_FETCH = 1000_000_001000.
  - CW_<op> EXEC words, e.g. CMPI 0001_001_000010, LD 1011_010_100000, ST 1000_000_111000, OUT 0000_000_001001, JMP 0100_000_001000.
  - function is_mem_op.
- Sub-module instr_cw_decode: pure combinational opcode+flags → 13-bit control word, instantiated once.
  - The sequencer masks that word in ACCESS and substitutes CW_FETCH in FETCH.

Test Plan:
- Reset with reset_n=0 mid-ACCESS (ST, RAM_WAIT=3), asynchronously → outputs all 0 in the same cycle, no csRAM. After release: RST, then FETCH with incPC=1, oeALU=1.
- RAM_WAIT=0, LIT 0100 → FETCH 1 cycle, then EXEC with loadA=1, loadFlags=1, fun=010, oeOprnd=1. Back in FETCH at cycle 3.
- RAM_WAIT=2, LD 0110 → FETCH, then ACCESS×2 (csRAM=1, loadA=0), then EXEC (incPC=1, loadA=1, loadFlags=1, fun=010, csRAM=1), then FETCH. 4 cycles total.
- JZ with z=1 → EXEC loadPC=1, incPC=0. JZ with z=0 → incPC=1, loadPC=0. JNC with c=1 → incPC=1.
- halt=1 asserted during EXEC of ADDI → instruction completes. At the next FETCH the state enters HALT (halted=1, incPC=0). After halt=0, FETCH follows one cycle later.
- ST with RAM_WAIT=1, with instr changed to 0100 during ACCESS → weRAM=1 throughout ACCESS and EXEC. The EXEC word still equals the ST word.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the nibble CPU sequencer: state encodings, opcodes,
// ALU function codes and the 13-bit datapath control word layout.
package cpu_pkg;

  // Low two bits of the first four states double as the reported phase.
  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } stateT;

  localparam logic [3:0] OP_JC    = 4'b0000;
  localparam logic [3:0] OP_JNC   = 4'b0001;
  localparam logic [3:0] OP_CMPI  = 4'b0010;
  localparam logic [3:0] OP_CMPM  = 4'b0011;
  localparam logic [3:0] OP_LIT   = 4'b0100;
  localparam logic [3:0] OP_IN    = 4'b0101;
  localparam logic [3:0] OP_LD    = 4'b0110;
  localparam logic [3:0] OP_ST    = 4'b0111;
  localparam logic [3:0] OP_JZ    = 4'b1000;
  localparam logic [3:0] OP_JNZ   = 4'b1001;
  localparam logic [3:0] OP_ADDI  = 4'b1010;
  localparam logic [3:0] OP_ADDM  = 4'b1011;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_OUT   = 4'b1101;
  localparam logic [3:0] OP_NANDI = 4'b1110;
  localparam logic [3:0] OP_NANDM = 4'b1111;

  localparam logic [2:0] FUN_PASS = 3'b000;
  localparam logic [2:0] FUN_CMP  = 3'b001;
  localparam logic [2:0] FUN_LOAD = 3'b010;
  localparam logic [2:0] FUN_ADD  = 3'b011;
  localparam logic [2:0] FUN_NAND = 3'b100;

  // Control word layout, MSB first:
  // incPC loadPC loadA loadFlags | fun[2:0] | csRAM weRAM oeALU oeIN oeOprnd loadOut
  typedef logic [12:0] cwT;

  localparam int CW_INCPC   = 12;
  localparam int CW_LOADPC  = 11;
  localparam int CW_LOADA   = 10;
  localparam int CW_LOADFLG = 9;
  localparam int CW_FUN_HI  = 8;
  localparam int CW_FUN_LO  = 6;
  localparam int CW_CSRAM   = 5;
  localparam int CW_WERAM   = 4;
  localparam int CW_OEALU   = 3;
  localparam int CW_OEIN    = 2;
  localparam int CW_OEOPRND = 1;
  localparam int CW_LOADOUT = 0;

  localparam cwT CW_FETCH = {4'b1000, FUN_PASS, 6'b001000};
  localparam cwT CW_HALT  = {4'b0000, FUN_PASS, 6'b001000};

  // Jump outcomes: taken loads the PC, not taken just steps past the operand.
  localparam cwT CW_JMP   = {4'b0100, FUN_PASS, 6'b001000};
  localparam cwT CW_JSKIP = {4'b1000, FUN_PASS, 6'b001000};

  localparam cwT CW_CMPI  = {4'b0001, FUN_CMP,  6'b000010};
  localparam cwT CW_CMPM  = {4'b1001, FUN_CMP,  6'b100000};
  localparam cwT CW_LIT   = {4'b0011, FUN_LOAD, 6'b000010};
  localparam cwT CW_IN    = {4'b0011, FUN_LOAD, 6'b000100};
  localparam cwT CW_LD    = {4'b1011, FUN_LOAD, 6'b100000};
  localparam cwT CW_ST    = {4'b1000, FUN_PASS, 6'b111000};
  localparam cwT CW_ADDI  = {4'b0011, FUN_ADD,  6'b000010};
  localparam cwT CW_ADDM  = {4'b1011, FUN_ADD,  6'b100000};
  localparam cwT CW_OUT   = {4'b0000, FUN_PASS, 6'b001001};
  localparam cwT CW_NANDI = {4'b0011, FUN_NAND, 6'b000010};
  localparam cwT CW_NANDM = {4'b1011, FUN_NAND, 6'b100000};

  // During a RAM wait only the ALU function, write enable and ALU drive of the
  // EXEC word survive; chip select is forced on.
  localparam cwT CW_ACCESS_KEEP  = 13'b0000_111_011000;
  localparam cwT CW_ACCESS_FORCE = 13'b0000_000_100000;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_CMPM) || (op == OP_LD) || (op == OP_ST) ||
           (op == OP_ADDM) || (op == OP_NANDM);
  endfunction

endpackage

// File: rtl/instr_cw_decode.sv
// Pure combinational decode of a latched opcode plus flags into the EXEC
// control word. Conditional jumps resolve to either a PC load or a PC step.
module instr_cw_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       zFlag,
  input  logic       cFlag,
  output cwT         cw
);

  // Opcode/flag lookup into the EXEC word table.
  always_comb begin
    cw = '0;
    unique case (opcode)
      OP_JC:    cw = cFlag  ? CW_JMP : CW_JSKIP;
      OP_JNC:   cw = !cFlag ? CW_JMP : CW_JSKIP;
      OP_CMPI:  cw = CW_CMPI;
      OP_CMPM:  cw = CW_CMPM;
      OP_LIT:   cw = CW_LIT;
      OP_IN:    cw = CW_IN;
      OP_LD:    cw = CW_LD;
      OP_ST:    cw = CW_ST;
      OP_JZ:    cw = zFlag  ? CW_JMP : CW_JSKIP;
      OP_JNZ:   cw = !zFlag ? CW_JMP : CW_JSKIP;
      OP_ADDI:  cw = CW_ADDI;
      OP_ADDM:  cw = CW_ADDM;
      OP_JMP:   cw = CW_JMP;
      OP_OUT:   cw = CW_OUT;
      OP_NANDI: cw = CW_NANDI;
      OP_NANDM: cw = CW_NANDM;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/execute controller for the nibble CPU. Generates its own phase,
// stretches memory instructions by RAM_WAIT access cycles and can park in
// HALT at an instruction boundary. All datapath strobes come from one
// 13-bit control word selected by state.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int RAM_WAIT = 0,
  parameter int WAIT_W   = 4,
  parameter int FUN_W    = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [3:0]       instr,
  input  logic             z_flag,
  input  logic             c_flag,
  input  logic             halt,
  output logic             incPC,
  output logic             loadPC,
  output logic             loadA,
  output logic             loadFlags,
  output logic [FUN_W-1:0] fun,
  output logic             csRAM,
  output logic             weRAM,
  output logic             oeALU,
  output logic             oeIN,
  output logic             oeOprnd,
  output logic             loadOut,
  output logic [1:0]       phase,
  output logic             halted
);

  localparam bit HAS_WAIT = (RAM_WAIT > 0);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = HAS_WAIT ? WAIT_W'(RAM_WAIT - 1) : '0;

  stateT             state;
  stateT             stateNext;
  logic [3:0]        opReg;
  logic [WAIT_W-1:0] waitCnt;
  cwT                decCw;
  cwT                cw;
  logic              fetchGo;

  // A fetch that is not diverted into HALT commits the instruction.
  assign fetchGo = (state == ST_FETCH) && !halt;

  instr_cw_decode uDecode (
    .opcode (opReg),
    .zFlag  (z_flag),
    .cFlag  (c_flag),
    .cw     (decCw)
  );

  // State register; reset drops any in-flight access immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_RST;
    else          state <= stateNext;
  end

  // RAM wait counter: preloaded when entering ACCESS, counts down to zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      waitCnt <= '0;
    else if (fetchGo && HAS_WAIT && is_mem_op(instr))
      waitCnt <= WAIT_LOAD;
    else if ((state == ST_ACCESS) && (waitCnt != '0))
      waitCnt <= waitCnt - WAIT_W'(1);
  end

  // Opcode capture, only at a committed fetch so later instr changes are ignored.
  always_ff @(posedge clock) begin
    if (fetchGo) opReg <= instr;
  end

  // Next-state and control word selection.
  always_comb begin
    stateNext = state;
    cw        = '0;
    phase     = 2'd0;
    halted    = 1'b0;
    unique case (state)
      ST_RST: begin
        stateNext = ST_FETCH;
      end
      ST_FETCH: begin
        cw    = CW_FETCH;
        phase = 2'd1;
        if (halt)                              stateNext = ST_HALT;
        else if (HAS_WAIT && is_mem_op(instr)) stateNext = ST_ACCESS;
        else                                   stateNext = ST_EXEC;
      end
      ST_ACCESS: begin
        cw    = (decCw & CW_ACCESS_KEEP) | CW_ACCESS_FORCE;
        phase = 2'd2;
        if (waitCnt == '0) stateNext = ST_EXEC;
      end
      ST_EXEC: begin
        cw        = decCw;
        phase     = 2'd3;
        stateNext = ST_FETCH;
      end
      ST_HALT: begin
        cw     = CW_HALT;
        halted = 1'b1;
        if (!halt) stateNext = ST_FETCH;
      end
      default: begin
        stateNext = ST_RST;
      end
    endcase
  end

  assign incPC     = cw[CW_INCPC];
  assign loadPC    = cw[CW_LOADPC];
  assign loadA     = cw[CW_LOADA];
  assign loadFlags = cw[CW_LOADFLG];
  assign fun       = FUN_W'(cw[CW_FUN_HI:CW_FUN_LO]);
  assign csRAM     = cw[CW_CSRAM];
  assign weRAM     = cw[CW_WERAM];
  assign oeALU     = cw[CW_OEALU];
  assign oeIN      = cw[CW_OEIN];
  assign oeOprnd   = cw[CW_OEOPRND];
  assign loadOut   = cw[CW_LOADOUT];

endmodule
